// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type, width helper and saturation functions for the conv accumulate stage
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} conv_acc_state_e;

  function automatic int acc_width(input int n);
    return 2 * n;
  endfunction

  function automatic logic signed [64:0] sat_max(input int w);
    return (65'sd1 <<< (w - 1)) - 65'sd1;
  endfunction

  function automatic logic signed [64:0] sat_min(input int w);
    return -(65'sd1 <<< (w - 1));
  endfunction

  function automatic logic is_sat(input logic signed [64:0] v, input int w);
    return (v > sat_max(w)) || (v < sat_min(w));
  endfunction

  function automatic logic signed [63:0] clamp_s(input logic signed [64:0] v, input int w);
    if (v > sat_max(w)) return 64'(sat_max(w));
    if (v < sat_min(w)) return 64'(sat_min(w));
    return 64'(v);
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    return clamp_s(65'(a) + 65'(b), w);
  endfunction

endpackage

// File: rtl/dual_port_bram.sv
// rtl/dual_port_bram.sv - simple dual-port RAM, one write port and one registered read port
module dual_port_bram #(
  parameter int DataWidth = 32,
  parameter int Depth     = 4096
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [DataWidth-1:0]     wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [DataWidth-1:0]     rdata_o
);

  logic [DataWidth-1:0] mem [Depth];

  // write port plus 1-cycle read; read data holds while re_i is low
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/requant_unit.sv
// rtl/requant_unit.sv - per-lane round/shift/saturate/ReLU; CONV_REQUANT_ROUND_EN enables round-half-up
module requant_unit
  import conv_pkg::*;
#(
  parameter int N  = 16,
  parameter int SW = $clog2(2 * N)
) (
  input  logic [2*N-1:0] sum_i,
  input  logic [SW-1:0]  shift_i,
  input  logic           relu_en_i,
  output logic [N-1:0]   data_o,
  output logic           ovf_o
);

  localparam int ACC_W = acc_width(N);

  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;
  logic signed [64:0]      wide;
  logic                    rnd_ovf;

  assign sum_s = signed'(sum_i);

`ifdef CONV_REQUANT_ROUND_EN
  logic signed [ACC_W-1:0] rnd_term;
  logic signed [64:0]      rnd_raw;
  // half an LSB of the shifted result; a zero shift has no fractional part to round
  assign rnd_term = (shift_i == '0) ? '0 : ACC_W'(1) << (shift_i - SW'(1));
  assign rnd_raw  = 65'(sum_s) + 65'(rnd_term);
  assign rounded  = ACC_W'(clamp_s(rnd_raw, ACC_W));
  assign rnd_ovf  = is_sat(rnd_raw, ACC_W);
`else
  assign rounded  = sum_s;
  assign rnd_ovf  = 1'b0;
`endif

  assign shifted = rounded >>> shift_i;
  assign wide    = 65'(shifted);
  assign ovf_o   = rnd_ovf || is_sat(wide, N);

  // clamp to activation range, then ReLU
  always_comb begin
    data_o = N'(clamp_s(wide, N));
    if (relu_en_i && data_o[N-1]) data_o = '0;
  end

endmodule

// File: rtl/conv_accum_requant.sv
// rtl/conv_accum_requant.sv - multi-pass partial-sum accumulate and requantise stage; CONV_REQUANT_ROUND_EN selects rounding
module conv_accum_requant
  import conv_pkg::*;
#(
  parameter int N          = 16,
  parameter int Channels   = 8,
  parameter int MaxOutputs = 4096
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic                                 first_pass_i,
  input  logic                                 last_pass_i,
  input  logic [$clog2(MaxOutputs+1)-1:0]      out_count_i,
  input  logic [$clog2(2*N)-1:0]               shift_i,
  input  logic                                 relu_en_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [Channels-1:0][2*N-1:0]         in_data_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [Channels-1:0][N-1:0]           out_data_o,
  output logic [$clog2(MaxOutputs)-1:0]        out_addr_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 ovf_o
);

  localparam int ACC_W = acc_width(N);
  localparam int CW    = $clog2(MaxOutputs + 1);
  localparam int AW    = $clog2(MaxOutputs);
  localparam int SW    = $clog2(2 * N);

  conv_acc_state_e state;
  logic            cfg_first, cfg_last, cfg_relu;
  logic [CW-1:0]   cfg_count;
  logic [SW-1:0]   cfg_shift;
  logic [AW-1:0]   addr;

  logic                           s0_valid;
  logic [Channels-1:0][ACC_W-1:0] s0_data;
  logic [AW-1:0]                  s0_addr;

  logic [Channels-1:0][ACC_W-1:0] rd_data;
  logic [Channels-1:0][ACC_W-1:0] sum;
  logic [Channels-1:0][N-1:0]     rq_data;
  logic [Channels-1:0]            acc_ovf;
  logic [Channels-1:0]            rq_ovf;

  logic adv, accept, last_beat, pipe_empty, ram_we;

  // the whole pipeline moves only when the output register can hand its beat on
  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = (state == RUN) && adv;
  assign accept     = in_valid_i && in_ready_o;
  assign last_beat  = (CW'(addr) == cfg_count - CW'(1));
  assign pipe_empty = !s0_valid && adv;
  assign ram_we     = adv && s0_valid;
  assign busy_o     = (state != IDLE);

  for (genvar c = 0; c < Channels; c++) begin : g_lane
    logic signed [ACC_W-1:0] prev;
    logic signed [ACC_W-1:0] cur;
    logic signed [64:0]      raw;

    assign prev        = cfg_first ? '0 : signed'(rd_data[c]);
    assign cur         = signed'(s0_data[c]);
    assign raw         = 65'(prev) + 65'(cur);
    assign sum[c]      = ACC_W'(sat_add(64'(prev), 64'(cur), ACC_W));
    assign acc_ovf[c]  = is_sat(raw, ACC_W);

    dual_port_bram #(
      .DataWidth(ACC_W),
      .Depth    (MaxOutputs)
    ) u_psum_ram (
      .clk_i  (clk_i),
      .we_i   (ram_we),
      .waddr_i(s0_addr),
      .wdata_i(sum[c]),
      .re_i   (adv),
      .raddr_i(addr),
      .rdata_o(rd_data[c])
    );

    requant_unit #(
      .N (N),
      .SW(SW)
    ) u_requant (
      .sum_i    (sum[c]),
      .shift_i  (cfg_shift),
      .relu_en_i(cfg_relu),
      .data_o   (rq_data[c]),
      .ovf_o    (rq_ovf[c])
    );
  end

  // pass sequencing, config latch, address counter, done pulse and sticky overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cfg_first <= 1'b0;
      cfg_last  <= 1'b0;
      cfg_relu  <= 1'b0;
      cfg_count <= '0;
      cfg_shift <= '0;
      addr      <= '0;
      done_o    <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (ram_we && ((|acc_ovf) || (cfg_last && (|rq_ovf)))) ovf_o <= 1'b1;
      case (state)
        IDLE: begin
          if (start_i) begin
            cfg_first <= first_pass_i;
            cfg_last  <= last_pass_i;
            cfg_relu  <= relu_en_i;
            cfg_count <= out_count_i;
            cfg_shift <= shift_i;
            addr      <= '0;
            ovf_o     <= 1'b0;
            if (out_count_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            addr <= addr + AW'(1);
            if (last_beat) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pipe_empty) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // S0 captures the accepted beat; S1 result is registered into the output on last passes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid    <= 1'b0;
      s0_data     <= '0;
      s0_addr     <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_addr_o  <= '0;
    end else if (adv) begin
      s0_valid <= accept;
      if (accept) begin
        s0_data <= in_data_i;
        s0_addr <= addr;
      end
      out_valid_o <= s0_valid && cfg_last;
      if (s0_valid && cfg_last) begin
        out_data_o <= rq_data;
        out_addr_o <= s0_addr;
      end
    end
  end

endmodule
